// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared types for the iterative ALU: pre-decoded control word, op select, FSM states.
// No logic here; mode constants feed the external decoder that drives signed_mode/carry_en.
// Optional divider hardware is selected by ALU_ITER_DIV_EN in the RTL that imports this.
package alu_pkg;

    typedef enum logic [1:0] {
        CSEL_SUM = 2'd0,
        CSEL_AND = 2'd1,
        CSEL_MUL = 2'd2,
        CSEL_DIV = 2'd3
    } csel_e;

    // Bit order matches the 8-bit ALU: za is bit 0, csel the top two bits.
    typedef struct packed {
        csel_e csel;
        logic  high;
        logic  po;
        logic  io;
        logic  ib;
        logic  zb;
        logic  ia;
        logic  za;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_EXEC = 2'd2,
        ST_FIN  = 2'd3
    } alu_state_e;

    localparam logic [7:0] MODE_UNSIGNED      = 8'h40;
    localparam logic [7:0] MODE_SIGNED        = 8'h41;
    localparam logic [7:0] MODE_CARRY         = 8'h42;
    localparam logic [7:0] MODE_SIGNED_CARRY  = 8'h43;
    localparam logic [7:0] MODE_NOCARRY       = 8'h44;

endpackage

// File: rtl/alu_muldiv_iter.sv
`timescale 1ns/1ps
// Shared shift-add multiplier / restoring divider (divider only with ALU_ITER_DIV_EN).
// Latency: loads on go, then WIDTH iterations; done is high during the final iteration cycle.
// No backpressure: parent holds off until done, results hold until the next go.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
`ifdef ALU_ITER_DIV_EN
    input  logic             div_sel,
`endif
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          running;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  shreg;
    logic [W-1:0]  m;
    logic [W:0]    add_c;
`ifdef ALU_ITER_DIV_EN
    logic          div_q;
    logic [W:0]    rem_sh_c;
    logic [W-1:0]  trial_c;
    logic          ge_c;
`endif

    always_comb begin
        add_c = {1'b0, acc} + (shreg[0] ? {1'b0, m} : {(W+1){1'b0}});
`ifdef ALU_ITER_DIV_EN
        // Shifted partial remainder needs W+1 bits; after a successful subtract it fits in W.
        rem_sh_c = {acc, shreg[W-1]};
        ge_c     = rem_sh_c >= {1'b0, m};
        trial_c  = rem_sh_c[W-1:0] - m;
`endif
    end

    assign done = running && (cnt == LAST);
    assign hi   = acc;
    assign lo   = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            shreg   <= '0;
            m       <= '0;
`ifdef ALU_ITER_DIV_EN
            div_q   <= 1'b0;
`endif
        end else if (go) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            shreg   <= opa;
            m       <= opb;
`ifdef ALU_ITER_DIV_EN
            div_q   <= div_sel;
`endif
        end else if (running) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
                running <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            if (div_q) begin
                acc   <= ge_c ? trial_c : rem_sh_c[W-1:0];
                shreg <= {shreg[W-2:0], ge_c};
            end else begin
                acc   <= add_c[W:1];
                shreg <= {add_c[0], shreg[W-1:1]};
            end
`else
            acc   <= add_c[W:1];
            shreg <= {add_c[0], shreg[W-1:1]};
`endif
        end
    end

endmodule

// File: rtl/alu_iter.sv
`timescale 1ns/1ps
// Multi-cycle ALU: SUM/AND/MUL/DIV with flags; divider present only with ALU_ITER_DIV_EN.
// Latency: done after edge 3 (SUM/AND/div-by-zero), edge 2+WIDTH (MUL/DIV).
// No backpressure: start is ignored while busy and is not queued.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_ctrl_t        ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             carry_en,
    input  logic             signed_mode,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             carryout,
    output logic             overout,
    output logic             zero,
    output logic             neg,
    output logic             div_err
);
    localparam int W = WIDTH;

    alu_state_e   state;
    alu_ctrl_t    ctrl_q;
    logic [W-1:0] a_q, b_q, xa_q, xb_q, result_q;
    logic         sgn_q, cin_q, sa_q, sb_q, iter_q;

    logic [W-1:0] xa_c, xb_c, ma_c, mb_c;
    logic         sa_c, sb_c, muldiv_c, iter_c, md_go;
    logic         md_done;
    logic [W-1:0] md_hi, md_lo;

    logic [W:0]     sum_c;
    logic [2*W-1:0] prod_raw, prod_c;
    logic [W-1:0]   r_c, rem_c;
    logic           cout_c, ov_c, derr_c, no_div_c;

    // Operand conditioning, evaluated while in PREP from the captured fields.
    always_comb begin
        xa_c     = (ctrl_q.za ? '0 : a_q) ^ {W{ctrl_q.ia}};
        xb_c     = (ctrl_q.zb ? '0 : b_q) ^ {W{ctrl_q.ib}};
        muldiv_c = (ctrl_q.csel == CSEL_MUL) || (ctrl_q.csel == CSEL_DIV);
        sa_c     = sgn_q && muldiv_c && xa_c[W-1];
        sb_c     = sgn_q && muldiv_c && xb_c[W-1];
        ma_c     = sa_c ? -xa_c : xa_c;
        mb_c     = sb_c ? -xb_c : xb_c;
`ifdef ALU_ITER_DIV_EN
        iter_c   = (ctrl_q.csel == CSEL_MUL) || ((ctrl_q.csel == CSEL_DIV) && (xb_c != '0));
`else
        iter_c   = (ctrl_q.csel == CSEL_MUL);
`endif
    end

    assign md_go = (state == ST_PREP) && iter_c;

    alu_muldiv_iter #(.WIDTH(W)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (md_go),
`ifdef ALU_ITER_DIV_EN
        .div_sel (ctrl_q.csel == CSEL_DIV),
`endif
        .opa     (ma_c),
        .opb     (mb_c),
        .done    (md_done),
        .hi      (md_hi),
        .lo      (md_lo)
    );

    // Final result and flags, registered on the FIN edge.
    always_comb begin
        sum_c    = {1'b0, xa_q} + {1'b0, xb_q} + (W+1)'(ctrl_q.po) + (W+1)'(cin_q);
        prod_raw = {md_hi, md_lo};
        prod_c   = (sgn_q && (sa_q ^ sb_q)) ? -prod_raw : prod_raw;
        r_c      = '0;
        rem_c    = '0;
        cout_c   = 1'b0;
        ov_c     = 1'b0;
        derr_c   = 1'b0;
        no_div_c = 1'b0;
        case (ctrl_q.csel)
            CSEL_SUM: begin
                r_c    = sum_c[W-1:0];
                cout_c = sum_c[W];
                ov_c   = (~sum_c[W-1] & xa_q[W-1] & xb_q[W-1]) |
                         (sum_c[W-1] & ~xa_q[W-1] & ~xb_q[W-1]);
            end
            CSEL_AND: r_c = xa_q & xb_q;
            CSEL_MUL: begin
                r_c  = ctrl_q.high ? prod_c[2*W-1:W] : prod_c[W-1:0];
                ov_c = sgn_q ? (prod_c[2*W-1:W] != {W{prod_c[W-1]}})
                             : (prod_c[2*W-1:W] != '0);
            end
            default: begin
`ifdef ALU_ITER_DIV_EN
                if (xb_q == '0) begin
                    r_c    = '1;
                    rem_c  = xa_q;
                    derr_c = 1'b1;
                end else begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    r_c   = (sgn_q && (sa_q ^ sb_q)) ? -md_lo : md_lo;
                    rem_c = (sgn_q && sa_q) ? -md_hi : md_hi;
                    ov_c  = sgn_q && (xa_q == {1'b1, {(W-1){1'b0}}}) && (xb_q == '1);
                end
`else
                derr_c   = 1'b1;
                no_div_c = 1'b1;
`endif
            end
        endcase
        if (!no_div_c)
            r_c = r_c ^ {W{ctrl_q.io}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            xa_q      <= '0;
            xb_q      <= '0;
            sgn_q     <= 1'b0;
            cin_q     <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            iter_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_q  <= '0;
            remainder <= '0;
            carryout  <= 1'b0;
            overout   <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        ctrl_q <= ctrl;
                        sgn_q  <= signed_mode;
                        cin_q  <= carry_en & carryin;
                        busy   <= 1'b1;
                        state  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    xa_q   <= xa_c;
                    xb_q   <= xb_c;
                    sa_q   <= sa_c;
                    sb_q   <= sb_c;
                    iter_q <= iter_c;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!iter_q || md_done)
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    result_q  <= r_c;
                    remainder <= rem_c;
                    carryout  <= cout_c;
                    overout   <= ov_c;
                    zero      <= (r_c == '0);
                    neg       <= r_c[W-1];
                    div_err   <= derr_c;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign result = oe ? result_q : '0;

endmodule

// File: tb/tb_alu_iter.sv
`timescale 1ns/1ps
// Directed bench for alu_iter at WIDTH=8; divider cases follow ALU_ITER_DIV_EN.
module tb_alu_iter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    alu_ctrl_t  ctrl;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       carryin = 1'b0, carry_en = 1'b0, signed_mode = 1'b0, oe = 1'b1;
    logic       busy, done, carryout, overout, zero, neg, div_err;
    logic [7:0] result, remainder;
    logic [4:0] fl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign fl = {carryout, overout, zero, neg, div_err};

    alu_iter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
        .carryin(carryin), .carry_en(carry_en), .signed_mode(signed_mode), .oe(oe),
        .busy(busy), .done(done), .result(result), .remainder(remainder),
        .carryout(carryout), .overout(overout), .zero(zero), .neg(neg), .div_err(div_err)
    );

    function automatic alu_ctrl_t mk(input csel_e cs, input logic hi, input logic po,
                                     input logic io, input logic ib, input logic zb,
                                     input logic ia, input logic za);
        alu_ctrl_t c;
        c.csel = cs; c.high = hi; c.po = po; c.io = io;
        c.ib = ib; c.zb = zb; c.ia = ia; c.za = za;
        return c;
    endfunction

    // Starts one op, scrambles operands after edge 0, returns edges-to-done (-1 on timeout).
    task automatic run_op(input alu_ctrl_t c, input logic [7:0] va, input logic [7:0] vb,
                          input logic ci, input logic ce, input logic sm,
                          output int lat, output logic busy0);
        ctrl = c; a = va; b = vb; carryin = ci; carry_en = ce; signed_mode = sm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busy0 = busy;
        a = ~va; b = ~vb; carryin = ~ci; signed_mode = ~sm;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset busy/done: got %b want 00", {busy, done}); end
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset result: got %h want 00", result); end
        n_cmp++; if (remainder !== 8'h00) begin n_bad++; $display("FAIL reset remainder: got %h want 00", remainder); end
        n_cmp++; if (fl !== 5'b00000) begin n_bad++; $display("FAIL reset flags: got %b want 00000", fl); end
    endtask

    task automatic test_sum();
        int lat; logic b0;
        run_op(mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0), 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sum_ovf latency: got %0d want 3", lat); end
        n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL sum_ovf busy at edge0: got %b want 1", b0); end
        n_cmp++; if (result !== 8'h80) begin n_bad++; $display("FAIL sum_ovf result: got %h want 80", result); end
        n_cmp++; if (fl !== 5'b01010) begin n_bad++; $display("FAIL sum_ovf flags: got %b want 01010", fl); end
        run_op(mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, lat, b0);
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL sum_cin result: got %h want 00", result); end
        n_cmp++; if (fl !== 5'b10100) begin n_bad++; $display("FAIL sum_cin flags: got %b want 10100", fl); end
    endtask

    task automatic test_subtract();
        int lat; logic b0;
        run_op(mk(CSEL_SUM, 0, 1, 0, 1, 0, 0, 0), 8'h05, 8'h07, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (result !== 8'hFE) begin n_bad++; $display("FAIL sub_neg result: got %h want FE", result); end
        n_cmp++; if (fl !== 5'b00010) begin n_bad++; $display("FAIL sub_neg flags: got %b want 00010", fl); end
        run_op(mk(CSEL_SUM, 0, 1, 0, 1, 0, 0, 0), 8'h07, 8'h05, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (result !== 8'h02) begin n_bad++; $display("FAIL sub_pos result: got %h want 02", result); end
        n_cmp++; if (fl !== 5'b10000) begin n_bad++; $display("FAIL sub_pos flags: got %b want 10000", fl); end
    endtask

    task automatic test_and();
        int lat; logic b0;
        run_op(mk(CSEL_AND, 0, 0, 1, 0, 0, 0, 0), 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL and_io latency: got %0d want 3", lat); end
        n_cmp++; if (result !== 8'hCF) begin n_bad++; $display("FAIL and_io result: got %h want CF", result); end
        n_cmp++; if (fl !== 5'b00010) begin n_bad++; $display("FAIL and_io flags: got %b want 00010", fl); end
        run_op(mk(CSEL_AND, 0, 0, 0, 0, 0, 1, 1), 8'h12, 8'h3C, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (result !== 8'h3C) begin n_bad++; $display("FAIL and_zaia result: got %h want 3C", result); end
    endtask

    task automatic test_mul();
        int lat; logic b0;
        run_op(mk(CSEL_MUL, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL mulu_lo latency: got %0d want 10", lat); end
        n_cmp++; if (result !== 8'h01) begin n_bad++; $display("FAIL mulu_lo result: got %h want 01", result); end
        n_cmp++; if (fl !== 5'b01000) begin n_bad++; $display("FAIL mulu_lo flags: got %b want 01000", fl); end
        run_op(mk(CSEL_MUL, 1, 0, 0, 0, 0, 0, 0), 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (result !== 8'hFE) begin n_bad++; $display("FAIL mulu_hi result: got %h want FE", result); end
        n_cmp++; if (fl !== 5'b01010) begin n_bad++; $display("FAIL mulu_hi flags: got %b want 01010", fl); end
        run_op(mk(CSEL_MUL, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, lat, b0);
        n_cmp++; if (result !== 8'h01) begin n_bad++; $display("FAIL muls_m1 result: got %h want 01", result); end
        n_cmp++; if (fl !== 5'b00000) begin n_bad++; $display("FAIL muls_m1 flags: got %b want 00000", fl); end
        run_op(mk(CSEL_MUL, 0, 0, 0, 0, 0, 0, 0), 8'hFD, 8'h05, 1'b0, 1'b0, 1'b1, lat, b0);
        n_cmp++; if (result !== 8'hF1) begin n_bad++; $display("FAIL muls_neg result: got %h want F1", result); end
        n_cmp++; if (fl !== 5'b00010) begin n_bad++; $display("FAIL muls_neg flags: got %b want 00010", fl); end
        n_cmp++; if (remainder !== 8'h00) begin n_bad++; $display("FAIL muls_neg remainder: got %h want 00", remainder); end
        oe = 1'b0; #1;
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL oe_low result: got %h want 00", result); end
        oe = 1'b1; #1;
        n_cmp++; if (result !== 8'hF1) begin n_bad++; $display("FAIL oe_hold result: got %h want F1", result); end
    endtask

    task automatic test_div();
        int lat; logic b0;
`ifdef ALU_ITER_DIV_EN
        run_op(mk(CSEL_DIV, 0, 0, 0, 0, 0, 0, 0), 8'hF9, 8'h02, 1'b0, 1'b0, 1'b1, lat, b0);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL divs latency: got %0d want 10", lat); end
        n_cmp++; if ({result, remainder} !== 16'hFDFF) begin n_bad++; $display("FAIL divs q/r: got %h want FDFF", {result, remainder}); end
        n_cmp++; if (fl !== 5'b00010) begin n_bad++; $display("FAIL divs flags: got %b want 00010", fl); end
        run_op(mk(CSEL_DIV, 0, 0, 0, 0, 0, 0, 0), 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, lat, b0);
        n_cmp++; if ({result, remainder} !== 16'h8000) begin n_bad++; $display("FAIL divs_min q/r: got %h want 8000", {result, remainder}); end
        n_cmp++; if (fl !== 5'b01010) begin n_bad++; $display("FAIL divs_min flags: got %b want 01010", fl); end
        run_op(mk(CSEL_DIV, 0, 0, 0, 0, 0, 0, 0), 8'hC8, 8'h07, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if ({result, remainder} !== 16'h1C04) begin n_bad++; $display("FAIL divu q/r: got %h want 1C04", {result, remainder}); end
        run_op(mk(CSEL_DIV, 0, 0, 0, 0, 0, 0, 0), 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL div0 latency: got %0d want 3", lat); end
        n_cmp++; if ({result, remainder} !== 16'hFF2A) begin n_bad++; $display("FAIL div0 q/r: got %h want FF2A", {result, remainder}); end
        n_cmp++; if (fl !== 5'b00011) begin n_bad++; $display("FAIL div0 flags: got %b want 00011", fl); end
`else
        run_op(mk(CSEL_DIV, 0, 0, 0, 0, 0, 0, 0), 8'h2A, 8'h07, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL nodiv latency: got %0d want 3", lat); end
        n_cmp++; if ({result, remainder} !== 16'h0000) begin n_bad++; $display("FAIL nodiv q/r: got %h want 0000", {result, remainder}); end
        n_cmp++; if (fl !== 5'b00101) begin n_bad++; $display("FAIL nodiv flags: got %b want 00101", fl); end
        run_op(mk(CSEL_DIV, 0, 0, 1, 0, 0, 0, 0), 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL nodiv0 result: got %h want 00", result); end
        n_cmp++; if (fl !== 5'b00101) begin n_bad++; $display("FAIL nodiv0 flags: got %b want 00101", fl); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat; logic b0;
        run_op(mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0), 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, lat, b0);
        run_op(mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0), 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, lat, b0);
        n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL b2b accepted in done cycle: busy %b want 1", b0); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b latency: got %0d want 3", lat); end
        n_cmp++; if (result !== 8'h77) begin n_bad++; $display("FAIL b2b result: got %h want 77", result); end
        @(posedge clk); #1;
        n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL b2b done pulse width: done/busy %b want 00", {done, busy}); end
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        int first = -1;
        ctrl = mk(CSEL_MUL, 0, 0, 0, 0, 0, 0, 0); a = 8'h03; b = 8'h04; signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        ctrl = mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0); a = 8'h01; b = 8'h01;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        for (int i = 6; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; if (first < 0) first = i; end
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignored_start pulses: got %0d want 1", pulses); end
        n_cmp++; if (first !== 10) begin n_bad++; $display("FAIL ignored_start done edge: got %0d want 10", first); end
        n_cmp++; if (result !== 8'h0C) begin n_bad++; $display("FAIL ignored_start result: got %h want 0C", result); end
    endtask

    task automatic test_abort();
        int lat; logic b0;
        int pulses = 0;
        run_op(mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0), 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, lat, b0);
        ctrl = mk(CSEL_MUL, 1, 0, 0, 0, 0, 0, 0); a = 8'h0F; b = 8'h0F; signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort busy before reset: got %b want 1", busy); end
        rst_n = 1'b0; #1;
        n_cmp++; if ({busy, done, result, remainder, fl} !== 23'd0) begin n_bad++; $display("FAIL abort outputs: got %h want 0", {busy, done, result, remainder, fl}); end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort done pulses: got %0d want 0", pulses); end
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL abort result hold: got %h want 00", result); end
    endtask

    initial begin
        ctrl = mk(CSEL_SUM, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_sum();
        test_subtract();
        test_and();
        test_mul();
        test_div();
        test_back_to_back();
        test_ignored_start();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
